// File: rtl/interval_timer_prog.sv
// rtl/interval_timer_prog.sv - programmable prescaled interval timer with one-shot/auto-reload, hold and abort
module interval_timer_prog #(
    parameter int BITS       = 33,
    parameter int PRESC_BITS = 27,
    parameter int PRESCALE   = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [BITS-1:0] load_value_i,
    input  logic            auto_reload_i,
    input  logic            hold_i,
    input  logic            abort_i,
    output logic [BITS-1:0] remaining_o,
    output logic            busy_o,
    output logic            paused_o,
    output logic            expired_o,
    output logic            done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_EXPIRED
    } state_t;

    localparam logic [PRESC_BITS-1:0] PRESC_MAX = PRESC_BITS'(PRESCALE - 1);
    localparam logic [BITS-1:0]       REM_ONE   = BITS'(1);

    state_t                state_q;
    logic [BITS-1:0]       reload_q;
    logic                  mode_q;
    logic [PRESC_BITS-1:0] presc_q;
    logic [PRESC_BITS-1:0] presc_d;
    logic [BITS-1:0]       remaining_q;
    logic                  done_q;
    logic                  counting;
    logic                  tick;

    // The edge that leaves PAUSED also counts, so each held cycle adds exactly one clock.
    always_comb begin
        counting = ((state_q == S_RUN) || (state_q == S_PAUSED)) && !hold_i;
        presc_d  = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        tick     = counting && (presc_q == PRESC_MAX);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            reload_q    <= '0;
            mode_q      <= 1'b0;
            presc_q     <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q     <= S_IDLE;
                remaining_q <= '0;
                presc_q     <= '0;
            end else if (start_i) begin
                reload_q    <= load_value_i;
                mode_q      <= auto_reload_i;
                presc_q     <= '0;
                remaining_q <= load_value_i;
                if (load_value_i == '0) begin
                    state_q <= S_EXPIRED;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_RUN;
                end
            end else begin
                case (state_q)
                    S_RUN, S_PAUSED: begin
                        if (hold_i) begin
                            state_q <= S_PAUSED;
                        end else begin
                            state_q <= S_RUN;
                            presc_q <= presc_d;
                            if (tick) begin
                                if (remaining_q > REM_ONE) begin
                                    remaining_q <= remaining_q - REM_ONE;
                                end else begin
                                    done_q <= 1'b1;
                                    if (mode_q) begin
                                        remaining_q <= reload_q;
                                    end else begin
                                        remaining_q <= '0;
                                        state_q     <= S_EXPIRED;
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign remaining_o = remaining_q;
    assign busy_o      = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign paused_o    = (state_q == S_PAUSED);
    assign expired_o   = (state_q == S_EXPIRED);
    assign done_o      = done_q;

endmodule

// File: doc/interval_timer_prog.md
Name: interval_timer_prog

Overview:
Programmable interval timer. Generalises the fixed 5 s tick counter into a runtime-loadable, prescaled, pausable timer with one-shot and auto-reload modes. The traffic-light FSM uses one instance per phase-timing need. It loads the green, amber or red duration at phase entry and waits on a single-cycle done pulse.

Parameters:
BITS, 33, width of the load value and remaining-count registers
PRESC_BITS, 27, width of the prescaler counter
PRESCALE, 1, clocks per timer tick (1 = count clocks; 100_000_000 = 1 s tick at 100 MHz); legal range 1..2^PRESC_BITS-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  pulse; latch load_value and auto_reload, begin timing (restarts if already running)
load_value  input  BITS  interval length in ticks, sampled only on start
auto_reload  input  1  mode select sampled on start: 0 = one-shot, 1 = periodic
hold  input  1  level; freezes prescaler and remaining while high
abort  input  1  pulse; return to IDLE with no done
remaining  output  BITS  ticks left in the current interval
busy  output  1  high in RUN or PAUSED
paused  output  1  high in PAUSED
expired  output  1  level; one-shot completed, cleared by start, abort or reset
done  output  1  registered pulse, exactly one clock per completed interval

Behaviour:
- Registers:
  - reload register (BITS)
  - mode register
  - prescaler (PRESC_BITS)
  - remaining (BITS)
  - state: IDLE, RUN, PAUSED, EXPIRED
- Reset (async, reset=1): state=IDLE; remaining, prescaler, reload and mode = 0; done, busy, paused, expired = 0. Release is synchronous to clk.
- Per-edge priority, highest first: abort > start > hold > tick.
- abort, from any state:
  - state=IDLE, remaining=0, prescaler=0, done=0.
  - An interval finishing on the same edge produces no done.
- start, from any state, when abort=0:
  - reload=load_value, mode=auto_reload, remaining=load_value, prescaler=0, state=RUN.
  - A coincident tick is discarded and produces no done.
- start with load_value==0:
  - remaining=0, state=EXPIRED in both modes.
  - done=1 on the following edge, single pulse.
  - expired=1 from that edge.
- RUN with hold=1: next state PAUSED; prescaler and remaining frozen.
- PAUSED with hold=0: next state RUN; counting resumes from the frozen prescaler value.
- Paused cycles extend the interval one-for-one.
- Prescaler in RUN with hold=0:
  - If prescaler==PRESCALE-1: prescaler=0 and a tick occurs.
  - Otherwise prescaler increments.
- Tick with remaining>1: remaining decrements by 1.
- Tick with remaining==1:
  - done=1 on this edge, high for exactly the next cycle.
  - mode=1: remaining=reload, stay in RUN. The period is exactly reload*PRESCALE clocks and remaining never reads 0.
  - mode=0: remaining=0, state=EXPIRED.
- done is cleared on every edge where it is not set.
- Latency: start sampled at edge k → busy=1 and remaining=load_value after edge k. With no hold, done is high in the cycle after edge k+N*PRESCALE (N=load_value).
- Outputs: busy, paused and expired decode the state register. All outputs are registered or decoded from registers, with no combinational input-to-output path.
- EXPIRED holds until start or abort. hold has no effect in IDLE or EXPIRED.
- No wrap-around: remaining cannot underflow. load_value is used as unsigned, full BITS range.
- Changes to load_value or auto_reload while running have no effect until the next start.

Test Plan:
1. BITS=8, PRESCALE=4. reset 3 cycles, then start with load_value=3, auto_reload=0 → remaining 3,2,1,0 at edges k+4,k+8,k+12; done high one cycle after edge k+12 only; then expired=1, busy=0.
2. PRESCALE=4, start with load_value=2, auto_reload=1, run 40 cycles → done pulses every 8 clocks (5 pulses); remaining cycles 2,1,2,1; expired stays 0.
3. PRESCALE=4, load_value=3, hold high for 5 cycles mid-interval → paused=1 during hold, remaining frozen; done 5 cycles later than in scenario 1.
4. abort on the same edge as the final tick (remaining==1) → no done, state IDLE, remaining=0. Separately, start coincident with the final tick → no done, remaining reloads the new load_value.
5. start with load_value=0 → done for exactly one cycle after the next edge, expired=1, busy never asserts; repeat with auto_reload=1 → identical.
6. Assert reset asynchronously mid-RUN (between clock edges) → all outputs 0 immediately; the first start after release times correctly.
